traffic_phase_sequencer: RTL and testbench
==========================================

Name: traffic_phase_sequencer

Overview:
Sequences the two-approach intersection lights from the registered 2-bit traffic mode: normal, pedestrian, night or emergency.
- Steps through green, yellow and all-red phases using a tick-driven phase timer.
- Inserts a pedestrian walk phase on request, flashes lights at night, and forces all-red on emergency.
- Sits between the traffic mode register and the lamp/walk drivers.

Parameters:
- GREEN_TICKS, 8, green duration in ticks (>=1)
- YELLOW_TICKS, 3, yellow duration in ticks (>=1)
- ALLRED_TICKS, 1, all-red clearance in ticks (>=1)
- WALK_TICKS, 5, pedestrian walk duration in ticks (>=1)
- BLINK_TICKS, 2, night flash half-period in ticks (>=1)
- TW, 8, timer width; every duration must be <= 2^TW

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- tick  input  1  one-cycle time-base strobe; all timers advance only on tick
- mode  input  2  traffic mode: 11 emergency, 10 pedestrian, 01 normal day, 00 night
- ns_light  output  3  {red,yellow,green}, north-south
- ew_light  output  3  {red,yellow,green}, east-west
- walk  output  1  pedestrian walk lamp
- phase  output  4  current state encoding

Behaviour:
- All outputs are registered.
- Reset: state=AR_TO_NS, timer=ALLRED_TICKS-1, ped_pending=0, blink=0, ns_light=ew_light=100, walk=0.
- States and phase codes:
  - 0 AR_TO_NS, 1 NS_GREEN, 2 NS_YELLOW, 3 AR_TO_EW, 4 EW_GREEN, 5 EW_YELLOW, 6 PED_WALK, 7 NIGHT, 8 EMERGENCY.
  - Codes 9-15 are unused; if reached, go to AR_TO_NS.
- Lamps per state:
  - AR_*, PED_WALK, EMERGENCY: both 100.
  - NS_GREEN: ns=001, ew=100. NS_YELLOW: ns=010, ew=100.
  - EW_GREEN: ew=001, ns=100. EW_YELLOW: ew=010, ns=100.
  - PED_WALK: walk=1. walk=0 in every other state.
  - NIGHT: ns={0,blink,0}, ew={blink,0,0}.
- Timer:
  - Loaded with duration-1 on entry to every timed state.
  - Decrements on tick while nonzero.
  - Timed-state expiry = tick && timer==0; on that cycle the next state is entered and the timer reloads.
  - No tick means the state holds.
- Normal sequence: AR_TO_NS -> NS_GREEN -> NS_YELLOW -> AR_TO_EW -> EW_GREEN -> EW_YELLOW -> AR_TO_NS.
- ped_pending:
  - Set on any cycle with mode==10.
  - Cleared on entry to PED_WALK.
  - Set and clear in the same cycle: clear wins.
- AR_TO_NS / AR_TO_EW expiry, in priority order:
  - mode==11 -> EMERGENCY
  - ped_pending -> PED_WALK, recording dest = NS or EW
  - mode==00 -> NIGHT
  - otherwise the normal successor.
- PED_WALK expiry -> dest green.
- Emergency (mode==11) is evaluated every cycle, with or without tick:
  - NS_GREEN/EW_GREEN -> the matching yellow with a full yellow reload.
  - AR_*, PED_WALK, NIGHT -> EMERGENCY immediately.
  - A yellow completes its full time, then goes to EMERGENCY instead of the all-red state.
- EMERGENCY: untimed. Exits to AR_TO_NS on the first cycle with mode!=11.
- NIGHT: untimed.
  - blink toggles every BLINK_TICKS ticks (blink timer loaded BLINK_TICKS-1 on entry, blink=1 on entry).
  - Exits to AR_TO_NS on the first cycle with mode!=00, or to EMERGENCY if mode==11.
- Simultaneous expiry and emergency in a green: emergency rule applies, i.e. go to yellow.
- Reset mid-phase: immediate return to reset values; a pending pedestrian request is lost.

Optional Feature:
- Macro: TRAFFIC_PHASE_COUNTDOWN_EN.
- When defined:
  - Adds output port `remaining` [TW-1:0], registered, equal to the current timer value in timed states.
  - Reads 0 in NIGHT and EMERGENCY; resets to ALLRED_TICKS-1.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
Common setup: GREEN=4, YELLOW=2, ALLRED=1, WALK=3, BLINK=2.
1. Normal cycle: tick=1 every cycle, mode=01, release rst -> phase 0 for 1 cycle, 1 for 4, 2 for 2, 3 for 1, 4 for 4, 5 for 2, then back to 0 (cycle period 14).
2. Pedestrian: pulse mode=10 for one cycle during NS_GREEN, then mode=01 -> after AR_TO_EW, phase 6 for 3 cycles with walk=1 and all lamps red, then EW_GREEN.
3. Emergency preempt: mode=11 at the 2nd cycle of NS_GREEN -> NS_YELLOW next cycle for 2 ticks, then phase 8 with both lamps 100. mode=01 -> AR_TO_NS next cycle.
4. Tick gating: tick every 3rd cycle, mode=01 -> NS_GREEN lasts exactly 12 cycles; state and timer hold on non-tick cycles.
5. Night: mode=00 -> enters 7 at the next AR expiry; ns toggles 010/000 every 2 ticks and ew toggles 100/000. mode=01 -> AR_TO_NS next cycle.
6. Async reset asserted mid-EW_GREEN without a clock edge -> outputs go to reset values immediately; with the macro defined, remaining=0 in EMERGENCY.

Source files
------------

// File: rtl/traffic_phase_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : traffic_phase_sequencer                                      |
// | Description : Two-approach intersection phase sequencer. Walks the         |
// |               green / yellow / all-red cycle on a tick-driven countdown,   |
// |               inserts a pedestrian walk phase on request, flashes the      |
// |               lamps at night and forces all-red on emergency.              |
// | Ports       : clk       - system clock, rising edge                        |
// |               rst       - asynchronous active-high reset                   |
// |               tick      - one-cycle time-base strobe                       |
// |               mode      - 11 emergency, 10 pedestrian, 01 day, 00 night    |
// |               ns_light  - {red,yellow,green} north-south (registered)      |
// |               ew_light  - {red,yellow,green} east-west (registered)        |
// |               walk      - pedestrian walk lamp (registered)                |
// |               phase     - current state code (registered)                  |
// |               remaining - timer value, only with TRAFFIC_PHASE_COUNTDOWN_EN |
// | Options     : define TRAFFIC_PHASE_COUNTDOWN_EN to add the countdown port  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module traffic_phase_sequencer #(
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 1,
  parameter int WALK_TICKS   = 5,
  parameter int BLINK_TICKS  = 2,
  parameter int TW           = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic [1:0]    mode,
  output logic [2:0]    ns_light,
  output logic [2:0]    ew_light,
  output logic          walk,
  output logic [3:0]    phase
`ifdef TRAFFIC_PHASE_COUNTDOWN_EN
  ,
  output logic [TW-1:0] remaining
`endif
);

  typedef enum logic [3:0] {
    AR_TO_NS  = 4'd0,
    NS_GREEN  = 4'd1,
    NS_YELLOW = 4'd2,
    AR_TO_EW  = 4'd3,
    EW_GREEN  = 4'd4,
    EW_YELLOW = 4'd5,
    PED_WALK  = 4'd6,
    NIGHT     = 4'd7,
    EMERGENCY = 4'd8
  } state_t;

  localparam logic [1:0] MODE_NIGHT = 2'b00;
  localparam logic [1:0] MODE_PED   = 2'b10;
  localparam logic [1:0] MODE_EMERG = 2'b11;

  localparam logic [TW-1:0] GREEN_LOAD  = TW'(GREEN_TICKS - 1);
  localparam logic [TW-1:0] YELLOW_LOAD = TW'(YELLOW_TICKS - 1);
  localparam logic [TW-1:0] ALLRED_LOAD = TW'(ALLRED_TICKS - 1);
  localparam logic [TW-1:0] WALK_LOAD   = TW'(WALK_TICKS - 1);
  localparam logic [TW-1:0] BLINK_LOAD  = TW'(BLINK_TICKS - 1);

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  state_t        state;
  logic [TW-1:0] timer;
  logic          ped_pending;
  logic          dest_ns;      // walk phase returns to NS green when set
  logic          blink;
  logic [TW-1:0] blink_timer;

  state_t        state_nxt;
  logic [TW-1:0] timer_nxt;
  logic          ped_nxt;
  logic          dest_nxt;
  logic          blink_nxt;
  logic [TW-1:0] blink_timer_nxt;
  logic [2:0]    ns_nxt;
  logic [2:0]    ew_nxt;
  logic          walk_nxt;

  logic expire;
  logic emerg;
  logic timed;

  assign expire = tick && (timer == '0);
  assign emerg  = (mode == MODE_EMERG);
  assign timed  = (state == AR_TO_NS) || (state == NS_GREEN) || (state == NS_YELLOW) ||
                  (state == AR_TO_EW) || (state == EW_GREEN) || (state == EW_YELLOW) ||
                  (state == PED_WALK);

  // Next-state, timer and side-state computation
  always_comb begin
    state_nxt       = state;
    timer_nxt       = timer;
    ped_nxt         = ped_pending | (mode == MODE_PED);
    dest_nxt        = dest_ns;
    blink_nxt       = blink;
    blink_timer_nxt = blink_timer;

    case (state)
      AR_TO_NS, AR_TO_EW: begin
        if (emerg) begin
          state_nxt = EMERGENCY;
        end else if (expire) begin
          if (ped_pending) begin
            state_nxt = PED_WALK;
            dest_nxt  = (state == AR_TO_NS);
          end else if (mode == MODE_NIGHT) begin
            state_nxt = NIGHT;
          end else begin
            state_nxt = (state == AR_TO_NS) ? NS_GREEN : EW_GREEN;
          end
        end
      end
      // Emergency cuts a green short but still passes through yellow
      NS_GREEN:  if (emerg || expire) state_nxt = NS_YELLOW;
      EW_GREEN:  if (emerg || expire) state_nxt = EW_YELLOW;
      // A yellow always runs its full time
      NS_YELLOW: if (expire) state_nxt = emerg ? EMERGENCY : AR_TO_EW;
      EW_YELLOW: if (expire) state_nxt = emerg ? EMERGENCY : AR_TO_NS;
      PED_WALK: begin
        if (emerg) begin
          state_nxt = EMERGENCY;
        end else if (expire) begin
          state_nxt = dest_ns ? NS_GREEN : EW_GREEN;
        end
      end
      NIGHT: begin
        if (emerg) begin
          state_nxt = EMERGENCY;
        end else if (mode != MODE_NIGHT) begin
          state_nxt = AR_TO_NS;
        end else if (tick) begin
          if (blink_timer == '0) begin
            blink_nxt       = ~blink;
            blink_timer_nxt = BLINK_LOAD;
          end else begin
            blink_timer_nxt = blink_timer - TW'(1);
          end
        end
      end
      EMERGENCY: if (!emerg) state_nxt = AR_TO_NS;
      default:   state_nxt = AR_TO_NS;
    endcase

    // Entry actions; an unused code always counts as a change of state
    if (state_nxt != state) begin
      case (state_nxt)
        AR_TO_NS, AR_TO_EW:   timer_nxt = ALLRED_LOAD;
        NS_GREEN, EW_GREEN:   timer_nxt = GREEN_LOAD;
        NS_YELLOW, EW_YELLOW: timer_nxt = YELLOW_LOAD;
        PED_WALK:             timer_nxt = WALK_LOAD;
        default:              timer_nxt = '0;
      endcase
      // Clearing on walk entry overrides a same-cycle request
      if (state_nxt == PED_WALK) ped_nxt = 1'b0;
      if (state_nxt == NIGHT) begin
        blink_nxt       = 1'b1;
        blink_timer_nxt = BLINK_LOAD;
      end
    end else if (timed && tick && (timer != '0)) begin
      timer_nxt = timer - TW'(1);
    end
  end

  // Lamp decode from the state being entered, so outputs are registered
  always_comb begin
    ns_nxt   = LAMP_RED;
    ew_nxt   = LAMP_RED;
    walk_nxt = 1'b0;
    case (state_nxt)
      NS_GREEN:  ns_nxt = LAMP_GREEN;
      NS_YELLOW: ns_nxt = LAMP_YELLOW;
      EW_GREEN:  ew_nxt = LAMP_GREEN;
      EW_YELLOW: ew_nxt = LAMP_YELLOW;
      PED_WALK:  walk_nxt = 1'b1;
      NIGHT: begin
        ns_nxt = {1'b0, blink_nxt, 1'b0};
        ew_nxt = {blink_nxt, 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= AR_TO_NS;
      timer       <= ALLRED_LOAD;
      ped_pending <= 1'b0;
      dest_ns     <= 1'b1;
      blink       <= 1'b0;
      blink_timer <= '0;
      ns_light    <= LAMP_RED;
      ew_light    <= LAMP_RED;
      walk        <= 1'b0;
      phase       <= AR_TO_NS;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      ped_pending <= ped_nxt;
      dest_ns     <= dest_nxt;
      blink       <= blink_nxt;
      blink_timer <= blink_timer_nxt;
      ns_light    <= ns_nxt;
      ew_light    <= ew_nxt;
      walk        <= walk_nxt;
      phase       <= state_nxt;
    end
  end

`ifdef TRAFFIC_PHASE_COUNTDOWN_EN
  // Untimed states show zero rather than a stale timer value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= ALLRED_LOAD;
    end else if ((state_nxt == NIGHT) || (state_nxt == EMERGENCY)) begin
      remaining <= '0;
    end else begin
      remaining <= timer_nxt;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_traffic_phase_sequencer                                   |
// | Description : Randomized self-checking bench for traffic_phase_sequencer.  |
// |               A phase-level reference model (duration table + elapsed     |
// |               tick counts) predicts lamps, walk and phase every cycle.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_traffic_phase_sequencer;

  localparam int GREEN  = 4;
  localparam int YELLOW = 2;
  localparam int ALLRED = 1;
  localparam int WALKT  = 3;
  localparam int BLINK  = 2;
  localparam int TW     = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [1:0] mode = 2'b01;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic [3:0] phase;
`ifdef TRAFFIC_PHASE_COUNTDOWN_EN
  logic [TW-1:0] remaining;
`endif

  traffic_phase_sequencer #(
    .GREEN_TICKS (GREEN),
    .YELLOW_TICKS(YELLOW),
    .ALLRED_TICKS(ALLRED),
    .WALK_TICKS  (WALKT),
    .BLINK_TICKS (BLINK),
    .TW          (TW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .mode     (mode),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .walk     (walk),
    .phase    (phase)
`ifdef TRAFFIC_PHASE_COUNTDOWN_EN
    ,
    .remaining(remaining)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_ph;       // phase number 0..8
  int m_el;       // ticks elapsed in the current timed phase
  bit m_ped;
  int m_dest;     // green phase to resume after walking
  int m_night;    // ticks seen while staying in night

  function automatic int dur(input int p);
    case (p)
      0, 3:    return ALLRED;
      1, 4:    return GREEN;
      2, 5:    return YELLOW;
      6:       return WALKT;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_timed(input int p);
    return p <= 6;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_el = 0; m_ped = 0; m_dest = 1; m_night = 0;
  endtask

  task automatic model_step(input bit t, input int m);
    int  nx;
    bit  ex;
    nx = m_ph;
    ex = t && is_timed(m_ph) && (m_el + 1 >= dur(m_ph));
    case (m_ph)
      0, 3: begin
        if (m == 3) nx = 8;
        else if (ex) begin
          if (m_ped) begin nx = 6; m_dest = (m_ph == 0) ? 1 : 4; end
          else if (m == 0) nx = 7;
          else nx = m_ph + 1;
        end
      end
      1, 4: if (m == 3 || ex) nx = m_ph + 1;
      2, 5: if (ex) nx = (m == 3) ? 8 : ((m_ph == 2) ? 3 : 0);
      6:    if (m == 3) nx = 8; else if (ex) nx = m_dest;
      7:    if (m == 3) nx = 8; else if (m != 0) nx = 0;
      default: if (m != 3) nx = 0;
    endcase
    if (m == 2) m_ped = 1;
    if (nx == 6 && m_ph != 6) m_ped = 0;
    if (nx != m_ph) begin
      m_el = 0;
      if (nx == 7) m_night = 0;
    end else if (t) begin
      if (m_ph == 7) m_night++;
      else if (is_timed(m_ph)) m_el++;
    end
    m_ph = nx;
  endtask

  function automatic logic [10:0] expected_out();
    logic [2:0] ns, ew;
    logic       w, b;
    ns = 3'b100; ew = 3'b100; w = 1'b0;
    b  = 1'b1 ^ logic'((m_night / BLINK) % 2);
    case (m_ph)
      1: ns = 3'b001;
      2: ns = 3'b010;
      4: ew = 3'b001;
      5: ew = 3'b010;
      6: w = 1'b1;
      7: begin ns = {1'b0, b, 1'b0}; ew = {b, 2'b00}; end
      default: ;
    endcase
    return {4'(m_ph), ns, ew, w};
  endfunction

  task automatic check_all(input string tag);
    chk(tag, {21'd0, phase, ns_light, ew_light, walk}, {21'd0, expected_out()});
`ifdef TRAFFIC_PHASE_COUNTDOWN_EN
    chk({tag, "_rem"}, {24'd0, remaining},
        is_timed(m_ph) ? 32'(dur(m_ph) - 1 - m_el) : 32'd0);
`endif
  endtask

  task automatic cycle(input bit t, input logic [1:0] m);
    tick = t;
    mode = m;
    @(posedge clk);
    model_step(t, int'(m));
    @(negedge clk);
    check_all("out");
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    // Day cycle with tick every cycle: two full 14-cycle rotations
    for (int i = 0; i < 28; i++) cycle(1'b1, 2'b01);

    // Randomized segments: hold a mode for a while with a random tick density
    for (int s = 0; s < 300; s++) begin
      logic [1:0] m;
      int         len, dens, r;
      r = int'($urandom_range(0, 99));
      if (r < 45)      m = 2'b01;
      else if (r < 60) m = 2'b10;
      else if (r < 80) m = 2'b00;
      else             m = 2'b11;
      len  = int'($urandom_range(1, 24));
      dens = int'($urandom_range(1, 3));   // tick 1-in-dens cycles on average
      for (int c = 0; c < len; c++)
        cycle(($urandom_range(1, dens) == 1), m);

      // Occasional asynchronous reset, asserted away from any clock edge
      if ($urandom_range(0, 19) == 0) begin
        #2 rst = 1'b1;
        #1 model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
